fetch_ctrl: RTL and testbench

//   Sequences instruction fetch: owns the PC, issues one-outstanding reads to a

---
 rtl/fetch_ctrl_if.sv | 36 +++
 rtl/fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Purpose : bundles the imem request/response, redirect and decode-side
//           handshake signals of the fetch controller into one port.
// Ports   : master = fetch_ctrl view (drives imem request and FIFO head),
//           slave  = surrounding pipeline view (drives redirect, imem
//           response and decode ready).
interface fetch_ctrl_if;
   // redirect from execute / trap logic
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   // instruction memory read port
   logic        o_imem_ren;
   logic [31:0] o_imem_raddr;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   // decode-side valid/ready
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready;

   modport master (
      input  i_redirect, i_redirect_pc,
      output o_imem_ren, o_imem_raddr,
      input  i_imem_rvalid, i_imem_rdata,
      output o_inst_valid, o_inst, o_inst_pc,
      input  i_inst_ready
   );

   modport slave (
      output i_redirect, i_redirect_pc,
      input  o_imem_ren, o_imem_raddr,
      output i_imem_rvalid, i_imem_rdata,
      input  o_inst_valid, o_inst, o_inst_pc,
      output i_inst_ready
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Purpose     : owns the PC, issues one-outstanding imem reads and buffers
//               returned words with their PCs toward decode; redirects flush
//               the buffer and discard the stale in-flight response.
// Latency     : ren at cycle N, rvalid at N+1 -> o_inst_valid at N+2; one
//               fetch per cycle with 1-cycle imem and decode always ready.
// Backpressure: a read issues only when a buffer slot is guaranteed for its
//               response, so decode stalls simply stop fetching.
// Ports       : i_clk, i_rst (async, active high), bus (fetch_ctrl_if.master:
//               redirect in, imem read port, decode valid/ready out).
module fetch_ctrl #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   fetch_ctrl_if.master bus
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // RUN  : nothing outstanding
   // WAIT : one read outstanding, its response is wanted
   // KILL : one read outstanding, its response belongs to a flushed path
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_KILL = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      req_pc_q, req_pc_d;

   entry_t           fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic             free_now;
   logic             push;
   logic             pop;
   logic             issue;
   logic [CNT_W:0]   occ_after;
   logic             unused_redirect_lsbs;

   // The redirect target is word aligned here; the low bits carry nothing.
   assign unused_redirect_lsbs = ^bus.i_redirect_pc[1:0];

   //------------------------------------------------------------------
   // Handshake decode
   //------------------------------------------------------------------
   // The outstanding slot frees up this cycle if nothing is in flight or
   // the in-flight response is arriving now (wanted or not).
   assign free_now = (state_q == ST_RUN) || bus.i_imem_rvalid;
   assign push     = (state_q == ST_WAIT) && bus.i_imem_rvalid && !bus.i_redirect;
   assign pop      = bus.o_inst_valid && bus.i_inst_ready && !bus.i_redirect;

   // Occupancy once this cycle's push/pop settle. pop implies count_q != 0,
   // so this never underflows.
   assign occ_after = {1'b0, count_q} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);

   // Issuing only when a slot remains after this cycle reserves room for the
   // response: with one read outstanding nothing else can push before it.
   // Reset gates the request so the port is quiet while i_rst is held.
   assign issue = !i_rst && free_now && !bus.i_redirect &&
                  (occ_after < (CNT_W+1)'(FIFO_DEPTH));

   assign bus.o_imem_ren   = issue;
   assign bus.o_imem_raddr = pc_q;

   //------------------------------------------------------------------
   // Fetch FSM
   //------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_ADDR;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;

      if (bus.i_redirect) begin
         // A read still in flight after this edge belongs to the old path.
         // New-path fetch starts on the next cycle at the earliest.
         pc_d = {bus.i_redirect_pc[31:2], 2'b00};
         if ((state_q != ST_RUN) && !bus.i_imem_rvalid) begin
            state_d = ST_KILL;
         end else begin
            state_d = ST_RUN;
         end
      end else if (issue) begin
         req_pc_d = pc_q;
         pc_d     = pc_q + 32'd4;
         state_d  = ST_WAIT;
      end else if (free_now) begin
         state_d = ST_RUN;
      end
   end

   //------------------------------------------------------------------
   // Instruction buffer
   //------------------------------------------------------------------
   // Storage is cleared on reset so the head outputs read zero until the
   // first word lands. A push and pop on a full buffer share the same slot
   // index safely: the head is read before the edge that overwrites it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (bus.i_redirect) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: req_pc_q, inst: bus.i_imem_rdata};
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= occ_after[CNT_W-1:0];
      end
   end

   assign bus.o_inst_valid = (count_q != '0);
   assign bus.o_inst       = fifo_q[rd_ptr_q].inst;
   assign bus.o_inst_pc    = fifo_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose : directed and randomized checks of fetch_ctrl against a queue-based
//           reference model; the bench also plays the instruction memory.
// Ports   : none (top-level bench).
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
   localparam int          DEPTH      = 2;

   logic i_clk = 1'b0;
   logic i_rst;

   always #5 i_clk = ~i_clk;

   fetch_ctrl_if bus ();

   fetch_ctrl #(
      .RESET_ADDR (RESET_ADDR),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   int tests = 0;
   int fails = 0;

   // reference model: buffered words in order, PC, one outstanding read
   ent_t        m_q [$];
   logic [31:0] m_pc;
   logic [31:0] m_req_pc;
   bit          m_out;
   bit          m_stale;

   // memory responder
   bit          mem_pend;
   int          mem_wait;
   logic [31:0] mem_addr;
   int          lat_min;
   int          lat_max;
   bit          inject_rv;

   // what the DUT showed in the most recent cycle
   logic        obs_ren;
   logic [31:0] obs_raddr;
   logic        obs_valid;
   logic [31:0] obs_pc;
   logic [31:0] obs_inst;

   bit          found;

   function automatic logic [31:0] memfn(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc      = RESET_ADDR;
      m_req_pc  = '0;
      m_out     = 1'b0;
      m_stale   = 1'b0;
      mem_pend  = 1'b0;
      mem_wait  = 0;
      inject_rv = 1'b0;
   endtask

   // One clock cycle: drive inputs, check outputs at the falling edge,
   // advance the model and the memory, then move just past the rising edge.
   task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
      logic        rv;
      logic [31:0] rd;
      bit          resp, pushed, popped, exp_ren;
      int          occ;

      rv = 1'b0;
      rd = '0;
      if (mem_pend) begin
         if (mem_wait == 0) begin
            rv       = 1'b1;
            rd       = memfn(mem_addr);
            mem_pend = 1'b0;
         end else begin
            mem_wait--;
         end
      end
      if (inject_rv) begin
         rv        = 1'b1;
         rd        = 32'hBAD0_BAD0;
         inject_rv = 1'b0;
      end

      bus.i_imem_rvalid = rv;
      bus.i_imem_rdata  = rd;
      bus.i_redirect    = redir;
      bus.i_redirect_pc = rpc;
      bus.i_inst_ready  = rdy;

      @(negedge i_clk);

      resp    = m_out && rv;
      pushed  = resp && !m_stale && !redir;
      popped  = (m_q.size() != 0) && rdy && !redir;
      occ     = m_q.size() + int'(pushed) - int'(popped);
      exp_ren = (!m_out || resp) && !redir && (occ < DEPTH);

      obs_ren   = bus.o_imem_ren;
      obs_raddr = bus.o_imem_raddr;
      obs_valid = bus.o_inst_valid;
      obs_pc    = bus.o_inst_pc;
      obs_inst  = bus.o_inst;

      check("ren", 32'(obs_ren), 32'(exp_ren));
      if (exp_ren) check("raddr", obs_raddr, m_pc);
      check("inst_valid", 32'(obs_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("inst_pc", obs_pc, m_q[0].pc);
         check("inst", obs_inst, m_q[0].inst);
      end

      if (redir) begin
         m_q.delete();
         m_pc = {rpc[31:2], 2'b00};
         if (resp) m_out = 1'b0;
         if (m_out) m_stale = 1'b1;
      end else begin
         if (popped) void'(m_q.pop_front());
         if (pushed) m_q.push_back('{pc: m_req_pc, inst: rd});
         if (resp) m_out = 1'b0;
         if (exp_ren) begin
            m_out    = 1'b1;
            m_stale  = 1'b0;
            m_req_pc = m_pc;
            m_pc     = m_pc + 32'd4;
         end
      end

      if (bus.o_imem_ren) begin
         mem_pend = 1'b1;
         mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
         mem_addr = bus.o_imem_raddr;
      end

      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      bus.i_redirect    = 1'b0;
      bus.i_redirect_pc = '0;
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = '0;
      bus.i_inst_ready  = 1'b0;
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      check("rst ren", 32'(bus.o_imem_ren), 32'd0);
      check("rst valid", 32'(bus.o_inst_valid), 32'd0);
      i_rst = 1'b0;
      model_reset();
   endtask

   initial begin
      lat_min = 1;
      lat_max = 1;
      model_reset();
      bus.i_redirect    = 1'b0;
      bus.i_redirect_pc = '0;
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = '0;
      bus.i_inst_ready  = 1'b0;
      i_rst = 1'b1;
      #1;
      check("reset ren", 32'(bus.o_imem_ren), 32'd0);
      check("reset valid", 32'(bus.o_inst_valid), 32'd0);
      check("reset inst", bus.o_inst, 32'd0);
      check("reset inst_pc", bus.o_inst_pc, 32'd0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      model_reset();

      // back-to-back fetch, 1-cycle memory, decode always ready
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         check("t1 ren", 32'(obs_ren), 32'd1);
         check("t1 raddr", obs_raddr, 32'(4 * i));
         if (i >= 2) begin
            check("t1 valid", 32'(obs_valid), 32'd1);
            check("t1 pc", obs_pc, 32'(4 * (i - 2)));
         end
      end

      // redirect coinciding with rvalid and a would-be pop
      cycle(1'b1, 32'h200, 1'b1);
      check("t4 no ren", 32'(obs_ren), 32'd0);
      cycle(1'b0, 32'h0, 1'b1);
      check("t4 flushed", 32'(obs_valid), 32'd0);
      check("t4 ren", 32'(obs_ren), 32'd1);
      check("t4 raddr", obs_raddr, 32'h200);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      check("t4 pc", obs_pc, 32'h200);

      // async reset in the middle of WAIT with a non-empty buffer
      i_rst = 1'b1;
      #2;
      check("t5 ren", 32'(bus.o_imem_ren), 32'd0);
      check("t5 valid", 32'(bus.o_inst_valid), 32'd0);
      check("t5 inst", bus.o_inst, 32'd0);
      check("t5 inst_pc", bus.o_inst_pc, 32'd0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      model_reset();
      inject_rv = 1'b1;
      cycle(1'b0, 32'h0, 1'b1);
      check("t5 first ren", 32'(obs_ren), 32'd1);
      check("t5 first raddr", obs_raddr, RESET_ADDR);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      check("t5 pc", obs_pc, RESET_ADDR);
      check("t5 inst", obs_inst, memfn(RESET_ADDR));

      // decode stalled from the start: buffer fills, fetch stops
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0);
      check("t2 ren stopped", 32'(obs_ren), 32'd0);
      check("t2 valid", 32'(obs_valid), 32'd1);
      check("t2 head", obs_pc, 32'h0);
      cycle(1'b0, 32'h0, 1'b1);
      check("t2 pop0", obs_pc, 32'h0);
      check("t2 resume ren", 32'(obs_ren), 32'd1);
      check("t2 resume raddr", obs_raddr, 32'h8);
      cycle(1'b0, 32'h0, 1'b1);
      check("t2 pop1", obs_pc, 32'h4);
      cycle(1'b0, 32'h0, 1'b1);
      check("t2 pop2", obs_pc, 32'h8);

      // 3-cycle memory, redirect while waiting -> stale word dropped
      do_reset();
      lat_min = 3;
      lat_max = 3;
      cycle(1'b0, 32'h0, 1'b1);
      check("t3 ren", 32'(obs_ren), 32'd1);
      cycle(1'b1, 32'h100, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      check("t3 empty", 32'(obs_valid), 32'd0);
      check("t3 held", 32'(obs_ren), 32'd0);
      cycle(1'b0, 32'h0, 1'b1);
      check("t3 drop ren", 32'(obs_ren), 32'd1);
      check("t3 drop raddr", obs_raddr, 32'h100);
      check("t3 drop valid", 32'(obs_valid), 32'd0);
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycle(1'b0, 32'h0, 1'b1);
         if (obs_valid && !found) begin
            check("t3 first pc", obs_pc, 32'h100);
            found = 1'b1;
         end
      end
      check("t3 word seen", 32'(found), 32'd1);

      // unaligned redirect target and PC wrap at the top of memory
      do_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'h103, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      check("t6 raddr", obs_raddr, 32'h100);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      check("t6 pc", obs_pc, 32'h100);
      cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      check("t6 top raddr", obs_raddr, 32'hFFFF_FFFC);
      cycle(1'b0, 32'h0, 1'b1);
      check("t6 wrap ren", 32'(obs_ren), 32'd1);
      check("t6 wrap raddr", obs_raddr, 32'h0);

      // randomized latency, stalls and redirects against the model
      do_reset();
      lat_min = 1;
      lat_max = 4;
      for (int n = 0; n < 1500; n++) begin
         bit          r_redir;
         logic [31:0] r_pc;
         bit          r_rdy;
         r_redir = ($urandom_range(99, 0) < 6);
         r_pc    = $urandom;
         r_rdy   = ($urandom_range(99, 0) < 70);
         cycle(r_redir, r_pc, r_rdy);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
